// File: rtl/frame_pixel_streamer_pkg.sv
// Shared definitions for the frame pixel streamer.
//   state_e : streamer FSM states
//   entry_t : skid FIFO entry {sof, eol, eof, pix}, i.e. sof=bit 10, eol=9, eof=8, pix=7:0
//   MaxWidthDef / MaxHeightDef : default largest accepted frame dimensions
package frame_pixel_streamer_pkg;

  localparam int unsigned MaxWidthDef  = 1024;
  localparam int unsigned MaxHeightDef = 1024;
  localparam int unsigned DimW         = 12;

  typedef enum logic [1:0] {
    StIdle,
    StActive,
    StHblank,
    StDrain
  } state_e;

  typedef struct packed {
    logic       sof;
    logic       eol;
    logic       eof;
    logic [7:0] pix;
  } entry_t;

endpackage

// File: rtl/frame_pixel_streamer_if.sv
// Frame RAM read port plus the tagged pixel output stream.
//   master : the streamer (drives RAM strobe/address and the pixel stream)
//   slave  : the environment (RAM data return and downstream ready)
interface frame_pixel_streamer_if #(
  parameter int unsigned ADDR_W = 20
);
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rd_data;
  logic              out_ready;
  logic [7:0]        data_out;
  logic              data_valid;
  logic              sof;
  logic              eol;
  logic              eof;

  modport master (
    output mem_rd_en, mem_addr, data_out, data_valid, sof, eol, eof,
    input  mem_rd_data, out_ready
  );

  modport slave (
    input  mem_rd_en, mem_addr, data_out, data_valid, sof, eol, eof,
    output mem_rd_data, out_ready
  );
endinterface

// File: rtl/frame_pixel_streamer_skid_fifo.sv
// Two-entry skid FIFO of tagged pixels. The head entry is a register, so the
// consumer sees registered data/tags directly.
//   clk, rst_n : clock, async active-low reset
//   push, din  : write an entry (allowed when full only together with pop)
//   pop        : drop the head entry (caller only pops when not empty)
//   head       : current head entry
//   count      : number of stored entries (0..2)
//   empty      : count == 0
module frame_pixel_streamer_skid_fifo
  import frame_pixel_streamer_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  entry_t     din,
  input  logic       pop,
  output entry_t     head,
  output logic [1:0] count,
  output logic       empty
);

  entry_t     mem_q [2];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      // When full, wr_ptr equals rd_ptr: a push+pop overwrites the slot being freed.
      if (push) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == 2'd0);

endmodule

// File: rtl/frame_pixel_streamer.sv
// Raster pixel source: reads one 8-bit frame from a synchronous-read RAM in raster
// order and streams it with sof/eol/eof tags, per-row blanking and ready backpressure.
//   clk, rst_n                  : clock, async active-low reset
//   start                       : frame request, sampled only when idle
//   frame_base/img_width/img_height/hblank : frame parameters, latched on accepted start
//   busy                        : accepted start until frame_done
//   frame_done                  : one-cycle pulse once the frame has fully drained
//   bus                         : RAM read port and output stream (master side)
module frame_pixel_streamer
  import frame_pixel_streamer_pkg::*;
#(
  parameter int unsigned MAX_WIDTH  = MaxWidthDef,
  parameter int unsigned MAX_HEIGHT = MaxHeightDef,
  parameter int unsigned ADDR_W     = 20
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   frame_base,
  input  logic [DimW-1:0]     img_width,
  input  logic [DimW-1:0]     img_height,
  input  logic [7:0]          hblank,
  output logic                busy,
  output logic                frame_done,
  frame_pixel_streamer_if.master bus
);

  localparam logic [DimW-1:0] MaxW = DimW'(MAX_WIDTH);
  localparam logic [DimW-1:0] MaxH = DimW'(MAX_HEIGHT);

  state_e            state_q;
  logic [DimW-1:0]   width_q, height_q, col_q, row_q;
  logic [7:0]        hblank_q, blank_cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic              outstanding_q;
  logic              pend_sof_q, pend_eol_q, pend_eof_q;
  logic              busy_q, done_q;

  entry_t     head;
  logic [1:0] fifo_count;
  logic       fifo_empty;
  logic       pop, issue, last_col, last_row, size_ok, drained;

  always_comb begin
    pop      = !fifo_empty && bus.out_ready;
    last_col = (col_q == width_q - 12'd1);
    last_row = (row_q == height_q - 12'd1);
    // Credit: buffered + in-flight, net of this cycle's pop, must leave room for one more.
    issue    = (state_q == StActive) &&
               (({1'b0, fifo_count} + {2'b0, outstanding_q}) < (3'd2 + {2'b0, pop}));
    size_ok  = (img_width != '0) && (img_width <= MaxW) &&
               (img_height != '0) && (img_height <= MaxH);
    // No reads in drain, so after this edge the FIFO is empty iff it holds only the popped beat.
    drained  = !outstanding_q && (fifo_count == {1'b0, pop});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      width_q       <= '0;
      height_q      <= '0;
      hblank_q      <= '0;
      blank_cnt_q   <= '0;
      col_q         <= '0;
      row_q         <= '0;
      addr_q        <= '0;
      outstanding_q <= 1'b0;
      pend_sof_q    <= 1'b0;
      pend_eol_q    <= 1'b0;
      pend_eof_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      done_q        <= 1'b0;
      outstanding_q <= issue;
      unique case (state_q)
        StIdle: begin
          if (start && size_ok) begin
            width_q  <= img_width;
            height_q <= img_height;
            hblank_q <= hblank;
            addr_q   <= frame_base;
            col_q    <= '0;
            row_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= StActive;
          end
        end
        StActive: begin
          if (issue) begin
            // Tags travel with the read and are joined with the returning pixel.
            pend_sof_q <= (row_q == '0) && (col_q == '0);
            pend_eol_q <= last_col;
            pend_eof_q <= last_col && last_row;
            addr_q     <= addr_q + ADDR_W'(1);
            if (last_col) begin
              col_q <= '0;
              row_q <= row_q + 12'd1;
              if (last_row) begin
                state_q <= StDrain;
              end else if (hblank_q != '0) begin
                blank_cnt_q <= hblank_q - 8'd1;
                state_q     <= StHblank;
              end
            end else begin
              col_q <= col_q + 12'd1;
            end
          end
        end
        StHblank: begin
          if (blank_cnt_q == '0) begin
            state_q <= StActive;
          end else begin
            blank_cnt_q <= blank_cnt_q - 8'd1;
          end
        end
        StDrain: begin
          if (drained) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
      endcase
    end
  end

  frame_pixel_streamer_skid_fifo u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (outstanding_q),
    .din   ('{sof: pend_sof_q, eol: pend_eol_q, eof: pend_eof_q, pix: bus.mem_rd_data}),
    .pop   (pop),
    .head  (head),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  // Read strobe is decoded from registered state so the first read lands in the cycle after start.
  assign bus.mem_rd_en  = issue;
  assign bus.mem_addr   = addr_q;
  assign bus.data_valid = !fifo_empty;
  assign bus.data_out   = head.pix;
  assign bus.sof        = head.sof;
  assign bus.eol        = head.eol;
  assign bus.eof        = head.eof;
  assign busy           = busy_q;
  assign frame_done     = done_q;

endmodule

// File: tb/tb_frame_pixel_streamer.sv
module tb_frame_pixel_streamer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [19:0] frame_base;
  logic [11:0] img_width;
  logic [11:0] img_height;
  logic [7:0]  hblank;
  logic        busy;
  logic        frame_done;

  frame_pixel_streamer_if #(.ADDR_W(20)) bus ();

  frame_pixel_streamer #(
    .MAX_WIDTH  (1024),
    .MAX_HEIGHT (1024),
    .ADDR_W     (20)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .frame_base (frame_base),
    .img_width  (img_width),
    .img_height (img_height),
    .hblank     (hblank),
    .busy       (busy),
    .frame_done (frame_done),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int start_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM content is a fixed function of the address.
  function automatic logic [7:0] pix_of(input logic [19:0] a);
    return a[7:0] ^ {a[11:8], a[19:16]} ^ 8'h5A;
  endfunction

  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rd_data <= pix_of(bus.mem_addr);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: expected read addresses and beats of the current frame.
  logic [19:0] exp_addr [$];
  logic [10:0] exp_beat [$];
  int          rd_rel [$];
  int          beat_rel [$];
  int          rd_total, beat_total, done_rel, mon_rel;
  bit          done_seen, prev_stall;
  logic [10:0] prev_beat, cur_beat;

  task automatic build_model(input logic [19:0] base, input int w, input int h);
    logic [19:0] a;
    exp_addr.delete(); exp_beat.delete(); rd_rel.delete(); beat_rel.delete();
    rd_total = 0; beat_total = 0; done_seen = 0; done_rel = -1; prev_stall = 0;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        a = 20'(int'(base) + r * w + c);
        exp_addr.push_back(a);
        exp_beat.push_back({(r == 0) && (c == 0), c == w - 1, (r == h - 1) && (c == w - 1),
                            pix_of(a)});
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon_rel  = cyc - start_cyc;
      cur_beat = {bus.sof, bus.eol, bus.eof, bus.data_out};
      if (prev_stall) check("hold_stable", 64'(cur_beat), 64'(prev_beat));
      prev_stall = bus.data_valid && !bus.out_ready;
      prev_beat  = cur_beat;
      if (bus.data_valid && bus.out_ready) begin
        beat_total++;
        beat_rel.push_back(mon_rel);
        if (exp_beat.size() == 0) fail("extra_beat", 64'(cur_beat), 0);
        else check($sformatf("beat%0d", beat_total - 1), 64'(cur_beat), 64'(exp_beat.pop_front()));
      end
      if (bus.mem_rd_en) begin
        rd_total++;
        rd_rel.push_back(mon_rel);
        if (exp_addr.size() == 0) fail("extra_read", 64'(bus.mem_addr), 0);
        else check("rd_addr", 64'(bus.mem_addr), 64'(exp_addr.pop_front()));
        check("inflight_le2", 64'((rd_total - beat_total) <= 2), 1);
      end
      if (frame_done) begin
        done_seen = 1;
        done_rel  = mon_rel;
        check("busy_low_at_done", 64'(busy), 0);
      end
    end
  end

  // rmode: 0 ready always, 1 random ready, 2 ready low for cycles 5..9 after start.
  task automatic run_frame(input logic [19:0] base, input int w, input int h, input int hb,
                           input int rmode, input bit poke);
    int r;
    build_model(base, w, h);
    @(posedge clk); #1;
    frame_base = base; img_width = 12'(w); img_height = 12'(h); hblank = 8'(hb);
    start = 1'b1; bus.out_ready = 1'b1; start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 2000 && !done_seen; k++) begin
      r = cyc - start_cyc;
      if (r == 1) check("busy_after_start", 64'(busy), 1);
      if (rmode == 0)      bus.out_ready = 1'b1;
      else if (rmode == 1) bus.out_ready = ($urandom_range(0, 3) != 0);
      else                 bus.out_ready = !(r >= 5 && r <= 9);
      if (poke && r == 4) begin
        start = 1'b1; frame_base = '0; img_width = 12'd2; img_height = 12'd1; hblank = 8'd0;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    if (!done_seen) fail("frame_done_timeout", 0, 1);
    check("frame_done_pulse", 64'(frame_done), 0);
    check("busy_after_done", 64'(busy), 0);
    check("reads_left", 64'(exp_addr.size()), 0);
    check("beats_left", 64'(exp_beat.size()), 0);
    if (beat_rel.size() != 0) check("done_after_last_beat", 64'(done_rel), 64'(beat_rel[$] + 1));
  endtask

  typedef struct {
    logic [19:0] base;
    int          w;
    int          h;
    int          hb;
    int          rmode;
    bit          poke;
    int          exp_beats;
    int          exp_first;  // -1: not checked
    int          exp_done;   // -1: not checked
  } vec_t;

  vec_t vecs [8];

  initial begin
    int w, h, hb;
    logic [19:0] base;

    vecs[0] = '{20'h00100, 4, 2, 0, 0, 1'b0, 8, 3, 11};
    vecs[1] = '{20'h00000, 1, 1, 0, 0, 1'b0, 1, 3, 4};
    vecs[2] = '{20'h00040, 3, 3, 2, 0, 1'b0, 9, 3, 16};
    vecs[3] = '{20'h12345, 1, 4, 1, 0, 1'b0, 4, 3, 10};
    vecs[4] = '{20'h20000, 5, 1, 7, 0, 1'b0, 5, 3, 8};
    vecs[5] = '{20'hFFFFE, 4, 1, 0, 0, 1'b0, 4, 3, 7};
    vecs[6] = '{20'h00200, 4, 2, 0, 0, 1'b1, 8, 3, 11};
    vecs[7] = '{20'h00300, 6, 2, 1, 1, 1'b0, 12, -1, -1};

    rst_n = 1'b0; start = 1'b0; frame_base = '0; img_width = '0; img_height = '0;
    hblank = '0; bus.out_ready = 1'b0; bus.mem_rd_data = '0;
    #2;
    check("rst_rd_en", 64'(bus.mem_rd_en), 0);
    check("rst_addr", 64'(bus.mem_addr), 0);
    check("rst_valid", 64'(bus.data_valid), 0);
    check("rst_data", 64'(bus.data_out), 0);
    check("rst_tags", 64'({bus.sof, bus.eol, bus.eof}), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_done", 64'(frame_done), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_frame(vecs[i].base, vecs[i].w, vecs[i].h, vecs[i].hb, vecs[i].rmode, vecs[i].poke);
      check($sformatf("vec%0d_beats", i), 64'(beat_total), 64'(vecs[i].exp_beats));
      if (vecs[i].exp_first >= 0 && beat_rel.size() != 0)
        check($sformatf("vec%0d_first", i), 64'(beat_rel[0]), 64'(vecs[i].exp_first));
      if (vecs[i].exp_first >= 0 && rd_rel.size() != 0)
        check($sformatf("vec%0d_first_rd", i), 64'(rd_rel[0]), 1);
      if (vecs[i].exp_done >= 0)
        check($sformatf("vec%0d_done", i), 64'(done_rel), 64'(vecs[i].exp_done));
    end

    // Row blanking: 3 idle read cycles and a 3-cycle valid gap between rows.
    run_frame(20'h00100, 4, 2, 3, 0, 1'b0);
    if (rd_rel.size() == 8 && beat_rel.size() == 8) begin
      check("hblank_rd_gap", 64'(rd_rel[4] - rd_rel[3]), 4);
      check("hblank_beat_gap", 64'(beat_rel[4] - beat_rel[3]), 4);
      check("hblank_row0_contig", 64'(beat_rel[3] - beat_rel[0]), 3);
    end else begin
      fail("hblank_counts", 64'(rd_rel.size()), 8);
    end

    // Five-cycle stall while beat 2 is presented.
    run_frame(20'h00800, 8, 1, 0, 2, 1'b0);
    check("stall_beats", 64'(beat_total), 8);
    if (beat_rel.size() > 2) check("stall_beat2_rel", 64'(beat_rel[2]), 10);
    else fail("stall_beat2_missing", 64'(beat_rel.size()), 3);

    // Illegal sizes: start ignored.
    for (int i = 0; i < 3; i++) begin
      build_model('0, 0, 0);
      @(posedge clk); #1;
      img_width  = (i == 0) ? 12'd0 : (i == 1) ? 12'd1025 : 12'd4;
      img_height = (i == 2) ? 12'd0 : 12'd2;
      start = 1'b1; start_cyc = cyc;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 0; k < 4; k++) begin
        check($sformatf("illegal%0d_busy", i), 64'(busy), 0);
        @(posedge clk); #1;
      end
      check($sformatf("illegal%0d_no_done", i), 64'(done_seen), 0);
      check($sformatf("illegal%0d_no_reads", i), 64'(rd_total), 0);
    end

    // Async reset in the middle of a row, then a clean frame.
    build_model(20'h00500, 8, 2);
    @(posedge clk); #1;
    frame_base = 20'h00500; img_width = 12'd8; img_height = 12'd2; hblank = 8'd0;
    start = 1'b1; bus.out_ready = 1'b1; start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("pre_rst_busy", 64'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rd_en", 64'(bus.mem_rd_en), 0);
    check("mid_rst_addr", 64'(bus.mem_addr), 0);
    check("mid_rst_valid", 64'(bus.data_valid), 0);
    check("mid_rst_data", 64'(bus.data_out), 0);
    check("mid_rst_tags", 64'({bus.sof, bus.eol, bus.eof}), 0);
    check("mid_rst_busy", 64'(busy), 0);
    @(posedge clk); #1;
    check("mid_rst_edge_valid", 64'(bus.data_valid), 0);
    check("mid_rst_edge_done", 64'(frame_done), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_frame(20'h00600, 4, 2, 0, 0, 1'b0);
    check("post_rst_beats", 64'(beat_total), 8);
    check("post_rst_done", 64'(done_rel), 11);

    // Randomized frames with random backpressure.
    for (int i = 0; i < 6; i++) begin
      w    = $urandom_range(1, 12);
      h    = $urandom_range(1, 4);
      hb   = $urandom_range(0, 4);
      base = 20'($urandom);
      run_frame(base, w, h, hb, 1, 1'b0);
      check($sformatf("rand%0d_beats", i), 64'(beat_total), 64'(w * h));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule
